// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: issues one request at a time to a variable-latency
// instruction memory and buffers returned words with their PC+4 for decode.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   imem_req_o,
    output logic [31:0]            imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [31:0]            imem_data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [31:0]            inst_o,
    output logic [31:0]            pc_plus4_o,
    input  logic                   flush_i,
    input  logic [31:0]            flush_pc_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [31:0]     pc_next4;

    logic [31:0]     inst_mem [DEPTH];
    logic [31:0]     pc4_mem  [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    logic            issue_ok;

    assign pc_next4   = fetch_pc + 32'd4;
    assign valid_o    = (count != '0);
    assign count_o    = count;
    assign push       = (state == WAIT) & imem_ack_i & ~flush_i;
    assign pop        = valid_o & ready_i & ~flush_i;
    assign count_next = count + CW'(push) - CW'(pop);
    // Slot for the next response is reserved at issue, so a push never finds the FIFO full.
    assign issue_ok   = start_i & ~flush_i & (count_next < CW'(DEPTH));

    assign inst_o     = valid_o ? inst_mem[rd_ptr] : 32'h0;
    assign pc_plus4_o = valid_o ? pc4_mem[rd_ptr]  : 32'h0;

    // Request FSM; imem_addr_o tracks fetch_pc except while a stale request drains.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        fetch_pc    <= flush_pc_i;
                        imem_addr_o <= flush_pc_i;
                    end else if (issue_ok) begin
                        state      <= WAIT;
                        imem_req_o <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_ack_i && flush_i) begin
                        fetch_pc    <= flush_pc_i;
                        imem_addr_o <= flush_pc_i;
                        state       <= IDLE;
                        imem_req_o  <= 1'b0;
                    end else if (imem_ack_i) begin
                        fetch_pc    <= pc_next4;
                        imem_addr_o <= pc_next4;
                        if (!issue_ok) begin
                            state      <= IDLE;
                            imem_req_o <= 1'b0;
                        end
                    end else if (flush_i) begin
                        fetch_pc <= flush_pc_i;
                        state    <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (flush_i) begin
                        fetch_pc <= flush_pc_i;
                    end
                    if (imem_ack_i) begin
                        state       <= IDLE;
                        imem_req_o  <= 1'b0;
                        imem_addr_o <= flush_i ? flush_pc_i : fetch_pc;
                    end
                end
                default: begin
                    state      <= IDLE;
                    imem_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            inst_mem[wr_ptr] <= imem_data_i;
            pc4_mem[wr_ptr]  <= pc_next4;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, hand sequences for flush/reset
// corners, and random traffic against a transaction-level reference model.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_plus4_o;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic [2:0]  count_o;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .inst_o(inst_o), .pc_plus4_o(pc_plus4_o),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_pops = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: ack after cur_lat extra cycles of request.
    int wcnt = 0;
    int cur_lat = 0;
    int lat_cfg = 0;
    bit rand_lat = 1'b0;
    always @(negedge clk) begin
        if (!imem_req_o) begin
            wcnt       = 0;
            imem_ack_i = 1'b0;
        end else begin
            if (imem_ack_i) wcnt = 0;
            if (wcnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
            if (wcnt >= cur_lat) begin
                imem_ack_i  = 1'b1;
                imem_data_i = mem_word(imem_addr_o);
            end else begin
                imem_ack_i  = 1'b0;
                imem_data_i = $urandom();
                wcnt++;
            end
        end
    end

    // Reference model: expected queue contents and next fetch address.
    typedef struct { logic [31:0] inst; logic [31:0] pc4; } entry_t;
    entry_t      q[$];
    logic [31:0] exp_fetch = RESET_PC;
    bit          stale = 1'b0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always begin
        @(negedge clk);
        #4;
        if (rst_i) begin
            q.delete();
            exp_fetch = RESET_PC;
            stale     = 1'b0;
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
        end else begin
            check("m_count", 32'(count_o), 32'(q.size()));
            check("m_valid", 32'(valid_o), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("m_inst", inst_o, q[0].inst);
                check("m_pc4", pc_plus4_o, q[0].pc4);
            end else begin
                check("m_inst_empty", inst_o, 32'h0);
                check("m_pc4_empty", pc_plus4_o, 32'h0);
            end
            if (!stale) check("m_addr", imem_addr_o, exp_fetch);
            if (prev_req && imem_req_o && !prev_ack) check("m_addr_hold", imem_addr_o, prev_addr);
            prev_req  = imem_req_o;
            prev_ack  = imem_ack_i;
            prev_addr = imem_addr_o;
            if (flush_i) begin
                if (imem_req_o) stale = !imem_ack_i;
                q.delete();
                exp_fetch = flush_pc_i;
            end else begin
                if (q.size() != 0 && ready_i) begin
                    void'(q.pop_front());
                    n_pops++;
                end
                if (imem_req_o && imem_ack_i) begin
                    if (!stale) begin
                        q.push_back('{inst: mem_word(imem_addr_o), pc4: imem_addr_o + 32'd4});
                        exp_fetch = imem_addr_o + 32'd4;
                    end
                    stale = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic        start;
        logic        ready;
        logic        flush;
        logic [31:0] flush_pc;
        int          cycles;
        logic [31:0] e_count;
        logic        e_valid;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t tbl[15];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start_i = 1'b0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        rst_i   = 1'b1;
        tick(1);
        rst_i   = 1'b0;
    endtask

    task automatic wait_for(input string nm, input logic want_req, input bit use_addr,
                            input logic [31:0] want_addr, input int limit);
        int k;
        k = 0;
        while (!((imem_req_o === want_req) && (!use_addr || imem_addr_o === want_addr)) && k < limit) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (k >= limit) begin
            n_err++;
            $display("FAIL %s: timeout, req=%b addr=%h required req=%b addr=%h", nm, imem_req_o, imem_addr_o, want_req, want_addr);
        end
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // start ready flush flush_pc cycles | count valid req addr pc4
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1, 32'd0, 1'b0, 1'b1, 32'h0000_0000, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1, 32'd1, 1'b1, 1'b1, 32'h0000_0004, 32'h4};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         3, 32'd4, 1'b1, 1'b0, 32'h0000_0010, 32'h4};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1, 32'd3, 1'b1, 1'b1, 32'h0000_0010, 32'h8};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1, 32'd3, 1'b1, 1'b1, 32'h0000_0014, 32'hC};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1, 32'd3, 1'b1, 1'b0, 32'h0000_0018, 32'h10};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         3, 32'd0, 1'b0, 1'b0, 32'h0000_0018, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h100,       1, 32'd0, 1'b0, 1'b0, 32'h0000_0100, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1, 32'd0, 1'b0, 1'b1, 32'h0000_0100, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1, 32'd1, 1'b1, 1'b1, 32'h0000_0104, 32'h104};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         1, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         1, 32'd1, 1'b1, 1'b1, 32'h0000_0000, 32'h0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h0,         1, 32'd1, 1'b1, 1'b0, 32'h0000_0004, 32'h4};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h0,         1, 32'd0, 1'b0, 1'b0, 32'h0000_0004, 32'h0};

        tick(1);
        rst_i = 1'b0;

        // Reset state
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, RESET_PC);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_pc4", pc_plus4_o, 32'h0);

        // Directed table, single-cycle memory
        lat_cfg  = 0;
        rand_lat = 1'b0;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            start_i    = tbl[i].start;
            ready_i    = tbl[i].ready;
            flush_i    = tbl[i].flush;
            flush_pc_i = tbl[i].flush_pc;
            tick(tbl[i].cycles);
            check($sformatf("v%0d_count", i), 32'(count_o), tbl[i].e_count);
            check($sformatf("v%0d_valid", i), 32'(valid_o), 32'(tbl[i].e_valid));
            check($sformatf("v%0d_req", i), 32'(imem_req_o), 32'(tbl[i].e_req));
            check($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].e_addr);
            check($sformatf("v%0d_pc4", i), pc_plus4_o, tbl[i].e_pc4);
        end
        flush_i = 1'b0;

        // Flush one cycle into request 0x8 with slow memory: stale response discarded
        lat_cfg = 3;
        do_reset();
        start_i = 1'b1;
        ready_i = 1'b0;
        wait_for("disc_wait8", 1'b1, 1'b1, 32'h8, 40);
        flush_i    = 1'b1;
        flush_pc_i = 32'h40;
        tick(1);
        flush_i = 1'b0;
        check("disc_req", 32'(imem_req_o), 32'd1);
        check("disc_addr_stale", imem_addr_o, 32'h8);
        check("disc_count", 32'(count_o), 32'd0);
        check("disc_valid", 32'(valid_o), 32'd0);
        wait_for("disc_drop", 1'b0, 1'b0, 32'h0, 10);
        check("disc_idle_addr", imem_addr_o, 32'h40);
        check("disc_idle_count", 32'(count_o), 32'd0);
        tick(1);
        check("disc_reissue_req", 32'(imem_req_o), 32'd1);
        check("disc_reissue_addr", imem_addr_o, 32'h40);

        // Reset while waiting on request 0xC
        do_reset();
        start_i = 1'b1;
        ready_i = 1'b1;
        wait_for("rstmid_wait", 1'b1, 1'b1, 32'hC, 40);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check("rstmid_req", 32'(imem_req_o), 32'd0);
        check("rstmid_count", 32'(count_o), 32'd0);
        check("rstmid_addr", imem_addr_o, RESET_PC);
        check("rstmid_valid", 32'(valid_o), 32'd0);

        // Random traffic against the reference model
        rand_lat = 1'b1;
        do_reset();
        n_pops = 0;
        for (int c = 0; c < 3000; c++) begin
            start_i    = ($urandom() % 8) != 0;
            ready_i    = ($urandom() % 4) != 0;
            flush_i    = ($urandom() % 16) == 0;
            flush_pc_i = $urandom() & 32'hFFFF_FFFC;
            rst_i      = ($urandom() % 500) == 0;
            tick(1);
        end
        rst_i   = 1'b0;
        flush_i = 1'b0;
        tick(2);
        check("rand_progress", 32'(n_pops >= 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction fetch front-end between the PC/Instruction_Memory path and the IF/ID pipeline register. It issues one-at-a-time requests to a variable-latency instruction memory and buffers returned instructions with their PC+4 in a DEPTH-entry FIFO. It presents them to decode with a valid/ready handshake, where ready is driven by IF_ID_Write. A taken branch or jump flushes the queue, discards any in-flight response and redirects fetch.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; one clock; reset is synchronous and active-high
start_i  in  1  fetch enable; 0 = issue no new requests
imem_req_o  out  1  request to instruction memory, held until ack
imem_addr_o  out  32  request address, stable while imem_req_o=1
imem_ack_i  in  1  response valid; qualifies imem_data_i
imem_data_i  in  32  returned instruction word
valid_o  out  1  head entry valid
ready_i  in  1  decode accepts head (IF_ID_Write)
inst_o  out  32  head instruction; 32'h0 (NOP) when empty
pc_plus4_o  out  32  head PC+4; 32'h0 when empty
flush_i  in  1  redirect request (branch/jump taken)
flush_pc_i  in  32  redirect target
count_o  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, fetch_pc=RESET_PC, FIFO pointers and count cleared. Outputs: imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, inst_o=0, pc_plus4_o=0, count_o=0. Reset mid-request abandons it; imem must accept req dropping without ack.
- imem_req_o=1 exactly in WAIT and DISCARD. imem_addr_o=fetch_pc (registered). At most one request outstanding.
- issue_ok = start_i & !flush_i & (count after this cycle's push/pop < DEPTH). Space is reserved at issue, so a response always has room; there is no overflow path.
- IDLE: flush_i -> fetch_pc<=flush_pc_i, stay IDLE (no issue in flush cycle). Else issue_ok -> WAIT.
- WAIT, no ack: flush_i -> fetch_pc<=flush_pc_i, go DISCARD. Else stay.
- WAIT, ack, flush_i=0: push {imem_data_i, fetch_pc+4}, fetch_pc<=fetch_pc+4. issue_ok -> stay WAIT with the new address (back-to-back, 1 instr/cycle at 1-cycle latency). Else -> IDLE.
- WAIT, ack, flush_i=1: response dropped, fetch_pc<=flush_pc_i, go IDLE.
- DISCARD: keep req high with the stale address. ack -> drop data, go IDLE. flush_i in DISCARD -> fetch_pc<=flush_pc_i, and the ack rule still applies.
- flush_i: FIFO cleared same edge (count 0, pointers reset). Any pop that cycle is ignored. Flush has priority over push and pop.
- Output side: valid_o=(count!=0). inst_o/pc_plus4_o are combinational from the head entry, zero when empty. Pop when valid_o&ready_i&!flush_i.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into an empty FIFO is visible on valid_o the following cycle; there is no bypass.
- Pointers wrap mod DEPTH. fetch_pc wraps mod 2^32 (0xFFFF_FFFC+4=0).
- start_i=0: an outstanding request completes and is pushed normally. No new issue.
- Decode stall (ready_i=0) holds head outputs stable.

Test Plan:
- Reset, start_i=1, ack 1 cycle after req, ready_i=1: addresses 0x0,0x4,0x8,0xC issued on consecutive cycles; inst_o follows mem order with pc_plus4_o 0x4,0x8,0xC,0x10.
- ready_i=0 from reset: after 4 pushes count_o=4, imem_req_o=0. Raise ready_i -> 4 entries drain in order, next request addr 0x10.
- 3-cycle ack latency, flush_i pulse with flush_pc_i=0x40 one cycle into request 0x8: DISCARD entered, 0x8 response not pushed, valid_o=0, next request addr 0x40.
- flush_i coincident with ack of 0x8: response dropped, count_o=0, IDLE for 1 cycle, request 0x40 issued the next cycle.
- count_o=1, push and pop same cycle: count_o stays 1, new head is the pushed word after the old head pops.
- rst_i asserted while WAIT at addr 0xC: next cycle imem_req_o=0, count_o=0, imem_addr_o=RESET_PC, valid_o=0.
